// File: rtl/rr3_mux_feeder_if.sv
// Source and output handshake bundle for the three-way round-robin mux feeder.
// The feeder takes the slave modport. The sources and downstream sink take the master modport.
interface rr3_mux_feeder_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] x;
    logic             xv;
    logic             xr;
    logic [WIDTH-1:0] y;
    logic             yv;
    logic             yr;
    logic [WIDTH-1:0] z;
    logic             zv;
    logic             zr;
    logic             s1;
    logic             s2;
    logic [WIDTH-1:0] o;
    logic             ov;
    logic             ordy;

    modport master (
        output x, xv, y, yv, z, zv, ordy,
        input  xr, yr, zr, s1, s2, o, ov
    );

    modport slave (
        input  x, xv, y, yv, z, zv, ordy,
        output xr, yr, zr, s1, s2, o, ov
    );
endinterface

// File: rtl/rr3_mux_feeder.sv
// Round-robin arbiter that picks one of three valid/ready sources and registers the winning word.
// It also registers the S1/S2 select pair, so the downstream 2:1 mux chain reproduces that word.
module rr3_mux_feeder #(
    parameter int         WIDTH    = 2,
    parameter logic [1:0] INIT_PTR = 2'd2
) (
    input  logic               clk,
    input  logic               rst,
    rr3_mux_feeder_if.slave    bus
);

    logic [1:0]       ptr;
    logic [1:0]       ptr_eff;
    logic [2:0]       gnt;
    logic [1:0]       gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             load_en;

    // An out-of-range pointer value of 3 is treated the same as 2.
    assign ptr_eff = (ptr == 2'd3) ? 2'd2 : ptr;
    assign load_en = !bus.ov || bus.ordy;

    always_comb begin
        gnt = 3'b000;
        case (ptr_eff)
            2'd0: begin
                if (bus.yv)      gnt = 3'b010;
                else if (bus.zv) gnt = 3'b100;
                else if (bus.xv) gnt = 3'b001;
            end
            2'd1: begin
                if (bus.zv)      gnt = 3'b100;
                else if (bus.xv) gnt = 3'b001;
                else if (bus.yv) gnt = 3'b010;
            end
            default: begin
                if (bus.xv)      gnt = 3'b001;
                else if (bus.yv) gnt = 3'b010;
                else if (bus.zv) gnt = 3'b100;
            end
        endcase
    end

    always_comb begin
        gnt_idx  = 2'd0;
        gnt_data = bus.x;
        if (gnt[1]) begin
            gnt_idx  = 2'd1;
            gnt_data = bus.y;
        end else if (gnt[2]) begin
            gnt_idx  = 2'd2;
            gnt_data = bus.z;
        end
    end

    assign bus.xr = gnt[0] && load_en && !rst;
    assign bus.yr = gnt[1] && load_en && !rst;
    assign bus.zr = gnt[2] && load_en && !rst;

    // Each load updates the word, the selects and the priority pointer together.
    // A drain with no new grant clears only the valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ov <= 1'b0;
            bus.o  <= '0;
            bus.s1 <= 1'b0;
            bus.s2 <= 1'b0;
            ptr    <= INIT_PTR;
        end else if (load_en) begin
            if (gnt != 3'b000) begin
                bus.o  <= gnt_data;
                bus.ov <= 1'b1;
                bus.s1 <= (gnt_idx == 2'd1);
                bus.s2 <= (gnt_idx == 2'd2);
                ptr    <= gnt_idx;
            end else begin
                bus.ov <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr3_mux_feeder.md
Name: rr3_mux_feeder

Overview:
- Upstream stage for the two-level 3:2 mux datapath (two chained 2:1 muxes, selects S1/S2).
- Accepts three independent WIDTH-bit valid/ready source channels X, Y, Z and arbitrates among them round-robin.
- Registers the winning word and drives the matching S1/S2 select pair, so the mux chain's final output (O2) reproduces the granted word.
- Single output register stage; sustains one transfer per cycle.

Parameters:
- WIDTH, 2, data width of each source and of the output word.
- INIT_PTR, 2, source index treated as "last granted" at reset (0=X, 1=Y, 2=Z); default 2 makes X highest priority after reset.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- X  input  WIDTH  source 0 data.
- XV  input  1  source 0 valid.
- XR  output  1  source 0 ready.
- Y  input  WIDTH  source 1 data.
- YV  input  1  source 1 valid.
- YR  output  1  source 1 ready.
- Z  input  WIDTH  source 2 data.
- ZV  input  1  source 2 valid.
- ZR  output  1  source 2 ready.
- S1  output  1  first-level mux select (registered).
- S2  output  1  second-level mux select (registered).
- O  output  WIDTH  registered granted word.
- OV  output  1  output valid.
- ORDY  input  1  downstream ready.

Behaviour:
- Reset (RST=1 at a rising edge): OV=0, O=0, S1=0, S2=0, ptr=INIT_PTR. XR/YR/ZR are combinational, so they read 0 while RST=1. Reset overrides everything, including a transfer in progress; any pending output word is dropped.
- Handshake: a transfer occurs on a source when valid and ready are both 1 at a rising edge. The output is consumed when OV and ORDY are both 1.
- Source valid must hold and data must stay stable until accepted; the block does not check this.
- load_en = !OV | ORDY, combinational.
- Grant is combinational from XV/YV/ZV and ptr:
  - Search order starts at (ptr+1) mod 3 and wraps.
  - The first valid source wins.
  - No valid source means no grant.
- Only the granted source sees ready=1, and only when load_en=1. At most one of XR/YR/ZR is high in any cycle.
- On a grant with load_en=1, at the next edge:
  - O <= granted data, OV <= 1, ptr <= granted index.
  - S1/S2 <= encoding: X -> S1=0,S2=0; Y -> S1=1,S2=0; Z -> S1=0,S2=1.
- With no grant and ORDY=1 while OV=1: OV <= 0. O, S1, S2 and ptr hold their last values.
- While OV=1 and ORDY=0: O, S1, S2, OV and ptr hold, and all readies are 0 (backpressure).
- Latency: source accept to OV=1 is 1 cycle. Throughput: 1 word/cycle with ORDY held at 1.
- Simultaneous drain and load in the same cycle: the new word replaces the old one, OV stays 1, and there is no bubble.
- Fairness: with all three valid continuously, grants rotate X,Y,Z,X,... from reset. Any continuously-valid source waits at most 2 grants.
- ptr advances only on an actual grant; cycles with no valid source leave priority unchanged.
- State: the output register plus the 2-bit ptr. ptr values are 0..2; value 3 is unreachable, and if forced it must be treated as 2.

Test Plan:
- Reset: assert RST 2 cycles with XV=YV=ZV=1 -> XR=YR=ZR=0, OV=0, O=0, S1=S2=0. Release -> first grant is X.
- Rotation: XV=YV=ZV=1, X=1, Y=2, Z=3, ORDY=1 -> O sequence 1,2,3,1,2,3 on consecutive cycles; (S1,S2) sequence (0,0),(1,0),(0,1) repeating; OV stays 1 throughout.
- Skip idle source: only XV=1 and ZV=1, X=1, Z=3, ORDY=1 -> O alternates 1,3; YR is never 1; ptr never equals 1.
- Backpressure: OV=1 holding O=2 (Y) with ORDY=0 for 3 cycles -> O=2, S1=1, S2=0 held and all readies 0. ORDY=1 with ZV=1, Z=3 -> next cycle O=3, S2=1, with no empty cycle.
- Drain to empty: a single X=1 transfer, then all valids 0 with ORDY=1 -> OV falls after 1 cycle; O and S1/S2 hold. Next YV=1 -> Y granted (ptr was X).
- Mid-operation reset: OV=1, ptr=Y, RST pulse for 1 cycle -> OV=0. First grant after release with all valids is X (INIT_PTR=2).
